// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/frame types, frame geometry and feeder state encoding.
package audio_pkg;
    typedef logic signed [15:0] sample_t;
    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_frame_t;
    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS = 16;
    typedef enum logic {FEED_IDLE, FEED_RUN} feed_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO, no bypass in either direction.
// Ports: clk, rst_n (sync, active-low, flushes), push/wrData, pop/rdData (rdData shows head),
//        full, empty, level (entries stored).
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic doPush;
    logic doPop;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign rdData = mem[rdPtr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop) rdPtr <= rdPtr + AW'(1);
            level <= level + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end
    always_ff @(posedge clk) if (doPush) mem[wrPtr] <= wrData;
endmodule

// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: buffers stereo frames and sequences them onto I2S bitclk/lrclk timing.
// Ports: clk, rst_n (sync, active-low), enable, sampleLeft/sampleRight/sampleValid/sampleReady
//        (producer handshake), bitclk, lrclk, dataOut (parallel word for the transmitter),
//        fifoLevel, underflowCount (saturating).
module i2s_sample_feeder
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [15:0]                   sampleLeft,
    input  logic [15:0]                   sampleRight,
    input  logic                          sampleValid,
    output logic                          sampleReady,
    output logic                          bitclk,
    output logic                          lrclk,
    output logic [15:0]                   dataOut,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic [7:0]                    underflowCount
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    feed_state_t state;
    feed_state_t nextState;
    logic startLoad;
    logic running;
    logic [DW-1:0] divCnt;
    logic [BW-1:0] bitCount;
    logic divTerm;
    logic rise;
    logic fall;
    logic popNow;
    logic rightNow;
    logic full;
    logic empty;
    sample_t rightHeld;
    stereo_frame_t wrFrame;
    stereo_frame_t rdFrame;

    assign sampleReady = rst_n && !full;
    assign wrFrame = '{left: sampleLeft, right: sampleRight};

    sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(stereo_frame_t))) fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(sampleValid && sampleReady),
        .wrData(wrFrame),
        .pop(popNow),
        .rdData(rdFrame),
        .full(full),
        .empty(empty),
        .level(fifoLevel)
    );

    always_ff @(posedge clk) state <= !rst_n ? FEED_IDLE : nextState;

    always_comb nextState = enable ? FEED_RUN : FEED_IDLE;

    // The first enabled cycle acts as the bitCount-31 falling transition, so every frame,
    // including the first, gets a full 16-bit left slot.
    always_comb begin
        startLoad = state == FEED_IDLE && enable;
        running = state == FEED_RUN && enable;
    end

    assign divTerm = divCnt == DW'(CLK_DIV - 1);
    assign rise = running && divTerm && !bitclk;
    assign fall = running && divTerm && bitclk;
    assign popNow = startLoad || (fall && bitCount == BW'(FRAME_BITS - 1));
    assign rightNow = fall && bitCount == BW'(SLOT_BITS - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            divCnt <= '0;
            bitclk <= 1'b0;
            lrclk <= 1'b0;
            bitCount <= '0;
            dataOut <= '0;
            rightHeld <= '0;
        end else begin
            if (startLoad) begin
                divCnt <= '0;
                bitCount <= BW'(FRAME_BITS - 1);
            end else begin
                divCnt <= divTerm ? '0 : divCnt + DW'(1);
                if (divTerm) bitclk <= !bitclk;
                if (rise) bitCount <= bitCount + BW'(1);
            end
            if (popNow) begin
                lrclk <= 1'b0;
                dataOut <= empty ? '0 : rdFrame.left;
                rightHeld <= empty ? '0 : rdFrame.right;
            end
            if (rightNow) begin
                lrclk <= 1'b1;
                dataOut <= rightHeld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) underflowCount <= '0;
        else if (popNow && empty && underflowCount != 8'hFF) underflowCount <= underflowCount + 8'd1;
    end
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb_i2s_sample_feeder: randomized self-checking bench against an arithmetic timing model.
module tb_i2s_sample_feeder;
    localparam int CD = 4;
    localparam int CD2 = 2;
    logic clk = 0;
    logic rst_n = 0;
    logic enable = 0;
    logic en2 = 0;
    logic [15:0] sampleLeft = 0;
    logic [15:0] sampleRight = 0;
    logic sampleValid = 0;
    logic sampleReady, bitclk, lrclk;
    logic [15:0] dataOut;
    logic [3:0] fifoLevel;
    logic [7:0] underflowCount;
    logic rdy2, bclk2, lr2;
    logic [15:0] data2;
    logic [3:0] lvl2;
    logic [7:0] und2;
    int errors = 0;
    int checks = 0;
    logic [15:0] qL [8];
    logic [15:0] qR [8];

    i2s_sample_feeder #(.CLK_DIV(CD), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sampleLeft(sampleLeft), .sampleRight(sampleRight), .sampleValid(sampleValid),
        .sampleReady(sampleReady), .bitclk(bitclk), .lrclk(lrclk), .dataOut(dataOut),
        .fifoLevel(fifoLevel), .underflowCount(underflowCount)
    );

    i2s_sample_feeder #(.CLK_DIV(CD2), .FIFO_DEPTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2),
        .sampleLeft(16'h0), .sampleRight(16'h0), .sampleValid(1'b0),
        .sampleReady(rdy2), .bitclk(bclk2), .lrclk(lr2), .dataOut(data2),
        .fifoLevel(lvl2), .underflowCount(und2)
    );

    always #5 clk = ~clk;

    // Model: n = cycles since the enabling edge; bitclk half-period CD, 32 bits per frame.
    function automatic logic mBclk(int n, int cd);
        return ((n / cd) % 2) == 1;
    endfunction

    function automatic logic mLr(int n, int cd);
        return ((n / (2 * cd)) % 32) >= 16;
    endfunction

    task automatic doReset();
        rst_n = 0;
        enable = 0;
        en2 = 0;
        sampleValid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic pushFrame(input logic [15:0] l, input logic [15:0] r);
        sampleLeft = l;
        sampleRight = r;
        sampleValid = 1;
        @(negedge clk);
        sampleValid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bitclk, lrclk, dataOut, fifoLevel, underflowCount, sampleReady} !== '0) begin
            errors++;
            $display("FAIL reset_values: got bclk=%b lr=%b data=%h lvl=%0d und=%0d rdy=%b, want all 0",
                     bitclk, lrclk, dataOut, fifoLevel, underflowCount, sampleReady);
        end
        rst_n = 1;
        #1;
        checks++;
        if (sampleReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", sampleReady);
        end
        @(negedge clk);
    endtask

    task automatic test_timing();
        int f;
        logic eLr;
        logic [15:0] eData;
        int eLvl;
        int eUnd;
        doReset();
        qL[0] = 16'h1234;
        qR[0] = 16'hABCD;
        for (int i = 1; i < 3; i++) begin
            qL[i] = 16'($urandom);
            qR[i] = 16'($urandom);
        end
        for (int i = 0; i < 3; i++) pushFrame(qL[i], qR[i]);
        checks++;
        if (fifoLevel !== 4'd3) begin
            errors++;
            $display("FAIL timing_prefill_level: got %0d want 3", fifoLevel);
        end
        enable = 1;
        for (int n = 0; n < 4 * 64 * CD; n++) begin
            @(negedge clk);
            f = n / (64 * CD);
            eLr = mLr(n, CD);
            eData = (f < 3) ? (eLr ? qR[f] : qL[f]) : 16'h0;
            eLvl = (f >= 2) ? 0 : 2 - f;
            eUnd = (f >= 3) ? f - 2 : 0;
            checks++;
            if (bitclk !== mBclk(n, CD) || lrclk !== eLr || dataOut !== eData ||
                fifoLevel !== 4'(eLvl) || underflowCount !== 8'(eUnd)) begin
                errors++;
                $display("FAIL timing n=%0d: got bclk=%b lr=%b data=%h lvl=%0d und=%0d want bclk=%b lr=%b data=%h lvl=%0d und=%0d",
                         n, bitclk, lrclk, dataOut, fifoLevel, underflowCount,
                         mBclk(n, CD), eLr, eData, eLvl, eUnd);
                break;
            end
        end
        enable = 0;
        @(negedge clk);
    endtask

    task automatic test_full();
        doReset();
        for (int i = 0; i < 8; i++) begin
            qL[i] = 16'($urandom);
            qR[i] = 16'($urandom);
            pushFrame(qL[i], qR[i]);
        end
        checks++;
        if (fifoLevel !== 4'd8 || sampleReady !== 1'b0) begin
            errors++;
            $display("FAIL full_level: got lvl=%0d rdy=%b want lvl=8 rdy=0", fifoLevel, sampleReady);
        end
        sampleLeft = 16'hDEAD;
        sampleRight = 16'hBEEF;
        sampleValid = 1;
        @(negedge clk);
        checks++;
        if (fifoLevel !== 4'd8) begin
            errors++;
            $display("FAIL full_ninth_refused: got lvl=%0d want 8", fifoLevel);
        end
        enable = 1;
        @(negedge clk);
        sampleValid = 0;
        checks++;
        if (fifoLevel !== 4'd7 || dataOut !== qL[0]) begin
            errors++;
            $display("FAIL full_pop_push: got lvl=%0d data=%h want lvl=7 data=%h", fifoLevel, dataOut, qL[0]);
        end
        enable = 0;
        @(negedge clk);
        checks++;
        if (fifoLevel !== 4'd7 || dataOut !== 16'h0 || bitclk !== 1'b0) begin
            errors++;
            $display("FAIL full_disable: got lvl=%0d data=%h bclk=%b want 7/0000/0", fifoLevel, dataOut, bitclk);
        end
        for (int i = 1; i <= 8; i++) begin
            enable = 1;
            @(negedge clk);
            checks++;
            if (dataOut !== (i < 8 ? qL[i] : 16'h0) || underflowCount !== (i < 8 ? 8'd0 : 8'd1)) begin
                errors++;
                $display("FAIL full_order i=%0d: got data=%h und=%0d want data=%h und=%0d",
                         i, dataOut, underflowCount, i < 8 ? qL[i] : 16'h0, i < 8 ? 0 : 1);
            end
            enable = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_midframe();
        int f;
        logic eLr;
        logic [15:0] eData;
        doReset();
        for (int i = 0; i < 2; i++) begin
            qL[i] = 16'($urandom);
            qR[i] = 16'($urandom);
            pushFrame(qL[i], qR[i]);
        end
        enable = 1;
        // Stop right after the rising edge that brings bitCount to 20.
        for (int n = 0; n <= CD * 41; n++) begin
            @(negedge clk);
            eLr = mLr(n, CD);
            eData = eLr ? qR[0] : qL[0];
            checks++;
            if (bitclk !== mBclk(n, CD) || lrclk !== eLr || dataOut !== eData) begin
                errors++;
                $display("FAIL midframe_run n=%0d: got bclk=%b lr=%b data=%h want %b/%b/%h",
                         n, bitclk, lrclk, dataOut, mBclk(n, CD), eLr, eData);
                break;
            end
        end
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bitclk !== 1'b0 || lrclk !== 1'b0 || dataOut !== 16'h0 || fifoLevel !== 4'd1) begin
                errors++;
                $display("FAIL midframe_stop i=%0d: got bclk=%b lr=%b data=%h lvl=%0d want 0/0/0000/1",
                         i, bitclk, lrclk, dataOut, fifoLevel);
            end
        end
        enable = 1;
        for (int n = 0; n < 64 * CD + 8; n++) begin
            @(negedge clk);
            f = n / (64 * CD);
            eLr = mLr(n, CD);
            eData = (f == 0) ? (eLr ? qR[1] : qL[1]) : 16'h0;
            checks++;
            if (bitclk !== mBclk(n, CD) || lrclk !== eLr || dataOut !== eData ||
                fifoLevel !== 4'd0 || underflowCount !== 8'(f)) begin
                errors++;
                $display("FAIL midframe_resume n=%0d: got bclk=%b lr=%b data=%h lvl=%0d und=%0d want %b/%b/%h/0/%0d",
                         n, bitclk, lrclk, dataOut, fifoLevel, underflowCount, mBclk(n, CD), eLr, eData, f);
                break;
            end
        end
        enable = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [15:0] l;
        doReset();
        for (int i = 0; i < 6; i++) pushFrame(16'($urandom), 16'($urandom));
        enable = 1;
        repeat (100) @(negedge clk);
        checks++;
        if (fifoLevel !== 4'd5) begin
            errors++;
            $display("FAIL rstmid_pre_level: got %0d want 5", fifoLevel);
        end
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({bitclk, lrclk, dataOut, fifoLevel, underflowCount, sampleReady} !== '0) begin
            errors++;
            $display("FAIL rstmid_values: got bclk=%b lr=%b data=%h lvl=%0d und=%0d rdy=%b want all 0",
                     bitclk, lrclk, dataOut, fifoLevel, underflowCount, sampleReady);
        end
        rst_n = 1;
        enable = 0;
        @(negedge clk);
        checks++;
        if (sampleReady !== 1'b1 || fifoLevel !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_release: got rdy=%b lvl=%0d want 1/0", sampleReady, fifoLevel);
        end
        l = 16'($urandom);
        pushFrame(l, 16'($urandom));
        enable = 1;
        @(negedge clk);
        checks++;
        if (dataOut !== l || fifoLevel !== 4'd0 || underflowCount !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_flushed: got data=%h lvl=%0d und=%0d want %h/0/0", dataOut, fifoLevel, underflowCount, l);
        end
        enable = 0;
        @(negedge clk);
    endtask

    task automatic test_underflow();
        int eUnd;
        doReset();
        en2 = 1;
        for (int n = 0; n < 300 * 64 * CD2; n++) begin
            @(negedge clk);
            eUnd = n / (64 * CD2) + 1;
            if (eUnd > 255) eUnd = 255;
            checks++;
            if (data2 !== 16'h0 || und2 !== 8'(eUnd) || bclk2 !== mBclk(n, CD2) || lr2 !== mLr(n, CD2)) begin
                errors++;
                $display("FAIL underflow n=%0d: got data=%h und=%0d bclk=%b lr=%b want 0000/%0d/%b/%b",
                         n, data2, und2, bclk2, lr2, eUnd, mBclk(n, CD2), mLr(n, CD2));
                break;
            end
        end
        checks++;
        if (und2 !== 8'd255 || rdy2 !== 1'b1 || lvl2 !== 4'd0) begin
            errors++;
            $display("FAIL underflow_sat: got und=%0d rdy=%b lvl=%0d want 255/1/0", und2, rdy2, lvl2);
        end
        en2 = 0;
        @(negedge clk);
    endtask

    task automatic test_end_to_end();
        logic prevB;
        logic prevLr;
        logic [15:0] word;
        logic [15:0] sh;
        logic [15:0] capL;
        logic [15:0] capR;
        int k;
        int got;
        doReset();
        pushFrame(16'h8001, 16'h7FFE);
        prevB = 0;
        prevLr = 1;
        k = 0;
        got = 0;
        word = 0;
        sh = 0;
        capL = 0;
        capR = 0;
        enable = 1;
        for (int n = 0; n < 64 * CD + 8; n++) begin
            @(negedge clk);
            if (bitclk && !prevB) begin
                if (lrclk != prevLr) begin
                    word = dataOut;
                    k = 0;
                    prevLr = lrclk;
                end
                checks++;
                if (dataOut !== word) begin
                    errors++;
                    $display("FAIL e2e_stable n=%0d: got %h want %h", n, dataOut, word);
                end
                if (k < 16) begin
                    sh = {sh[14:0], word[15 - k]};
                    k++;
                    if (k == 16) begin
                        if (lrclk) capR = sh;
                        else capL = sh;
                        got = got | (lrclk ? 2 : 1);
                    end
                end
            end
            prevB = bitclk;
        end
        checks++;
        if (got != 3 || capL !== 16'h8001 || capR !== 16'h7FFE) begin
            errors++;
            $display("FAIL e2e_capture: got L=%h R=%h slots=%0d want L=8001 R=7ffe slots=3", capL, capR, got);
        end
        enable = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_timing();
        test_full();
        test_midframe();
        test_reset_midframe();
        test_underflow();
        test_end_to_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_sample_feeder.md
I2S_SAMPLE_FEEDER -- requirements
Module: i2s_sample_feeder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per bitclk half-period, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: stereo frames buffered, power of two, range 2..64.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1: run serial timing when high.
REQ-006 SHALL have port sampleLeft, input, 16: left sample, signed two's complement.
REQ-007 SHALL have port sampleRight, input, 16: right sample, signed two's complement.
REQ-008 SHALL have port sampleValid, input, 1: producer offers a stereo frame.
REQ-009 SHALL have port sampleReady, output, 1: the block accepts the frame this cycle.
REQ-010 SHALL have port bitclk, output, 1: generated serial bit clock, driving the downstream transmitter.
REQ-011 SHALL have port lrclk, output, 1: word select; 0 = left, 1 = right.
REQ-012 SHALL have port dataOut, output, 16: parallel word for the downstream transmitter's dataIn.
REQ-013 SHALL have port fifoLevel, output, $clog2(FIFO_DEPTH)+1: frames currently stored.
REQ-014 SHALL have port underflowCount, output, 8: saturating count of empty-FIFO pops.

Function
REQ-015 SHALL accept a frame in each cycle where sampleValid && sampleReady; sampleReady = !full, registered-free (combinational from level).
REQ-016 SHALL NOT bypass: a full FIFO SHALL refuse a push even when a pop occurs in the same cycle, and an empty FIFO SHALL underflow even when a push occurs in the same cycle.
REQ-017 SHALL update fifoLevel by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-018 SHALL run a divider counter 0..CLK_DIV-1 while enable=1 and toggle bitclk at the terminal count, giving a period of 2*CLK_DIV clk cycles.
REQ-019 SHALL keep bitCount 0..31, advancing on every bitclk rising transition and wrapping 31->0 (frame = 16 left + 16 right bits).
REQ-020 SHALL change lrclk only on bitclk falling transitions: to 1 when bitCount is 15, and to 0 when bitCount is 31 (one bit ahead of the slot, I2S style).
REQ-021 SHALL pop one frame on the falling transition with bitCount 31 (and on the first falling transition after enable rises), load dataOut with left, and hold right in a register.
REQ-022 SHALL load dataOut with the held right sample on the falling transition with bitCount 15.
REQ-023 SHALL hold dataOut stable across every bitclk rising edge within a slot.
REQ-024 SHALL load 0 for both channels on a pop with the FIFO empty, and increment underflowCount, saturating at 255.
REQ-025 SHALL hold bitclk=0, lrclk=0, the divider at 0 and bitCount at 0 while enable=0; the FIFO keeps accepting and keeps its contents.
REQ-026 SHALL stop within one cycle on enable falling mid-frame: the REQ-025 values apply next cycle and dataOut is cleared to 0; the partial frame is discarded, not re-queued.
REQ-027 SHALL produce the first bitclk rising edge exactly CLK_DIV cycles after the first falling-transition load following enable rising.

Reset
REQ-028 SHALL set, while rst_n=0 at a clk edge: bitclk=0, lrclk=0, dataOut=0, fifoLevel=0, underflowCount=0, divider=0, bitCount=0, held right=0.
REQ-029 SHALL drive sampleReady=0 during reset and 1 in the first cycle after rst_n returns high.
REQ-030 SHALL flush FIFO contents on reset, including a reset mid-frame.

Structure
REQ-031 SHALL define, in shared package audio_pkg: sample_t (logic signed [15:0]), stereo_frame_t (packed struct left/right), FRAME_BITS=32, SLOT_BITS=16.
REQ-032 SHALL implement storage in one sub-module, sample_fifo (synchronous, parameterised depth and width, full/empty/level); timing and sequencing stay in the top level.

Verification
REQ-033 SHALL verify timing: CLK_DIV=4, enable=1, push (0x1234, 0xABCD) -> bitclk period 8 cycles; dataOut=0x1234 while lrclk=0, 0xABCD while lrclk=1; lrclk toggles every 16 bitclks.
REQ-034 SHALL verify full FIFO: 8 pushes with enable=0 -> fifoLevel=8, sampleReady=0; a 9th valid is not accepted; a pop plus a valid in the same cycle -> level 7.
REQ-035 SHALL verify underflow: enable=1 with an empty FIFO for 300 frames -> dataOut=0 throughout and underflowCount saturates at 255.
REQ-036 SHALL verify mid-frame enable drop: enable low at bitCount 20 -> next cycle bitclk=0, lrclk=0, dataOut=0, level unchanged; re-enable -> the next frame starts with a left slot.
REQ-037 SHALL verify reset mid-frame: rst_n=0 for 1 cycle with level 5 -> all REQ-028 values; sampleReady=1 in the cycle after release.
REQ-038 SHALL verify end-to-end: feeder drives the downstream transmitter; a serial capture of 0x8001/0x7FFE reproduces both words MSB first.
